debug_reg_dumper: RTL and testbench

//  Controller that takes the decode stage's register-bank debug read port and streams every register to the debug UART transmitter.

---
 rtl/debug_reg_dumper_pkg.sv | 18 +
 rtl/word_serializer.sv | 49 ++++
 rtl/debug_reg_dumper.sv | 128 ++++++++++++
 tb/tb_debug_reg_dumper.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_reg_dumper_pkg.sv
// debug_reg_dumper shared definitions: FSM encodings and byte geometry.
// Consumed by debug_reg_dumper and word_serializer.
package debug_reg_dumper_pkg;

  localparam int NB_BYTE        = 8;
  localparam int BYTES_PER_WORD = 32 / NB_BYTE;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_LATCH  = 3'd2,
    S_SEND   = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5,
    S_CSUM   = 3'd6
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// word_serializer: loads one register word and shifts it out MSB byte first
// over a valid/ready link; flags the handshake of the final byte.
module word_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_last_sent
);
  import debug_reg_dumper_pkg::*;

  localparam int BPW    = NB_DATA / NB_BYTE;
  localparam int NB_CNT = $clog2(BPW + 1);

  logic [NB_DATA-1:0] r_shift;
  logic [NB_CNT-1:0]  r_cnt;
  logic               r_valid;
  logic               w_xfer;

  assign w_xfer      = r_valid && i_tx_ready;
  assign o_last_sent = w_xfer && (r_cnt == NB_CNT'(BPW - 1));
  assign o_tx_data   = r_shift[NB_DATA-1 -: NB_BYTE];
  assign o_tx_valid  = r_valid;

  // Load a word, then advance one byte per accepted handshake
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_shift <= r_shift << NB_BYTE;
      r_cnt   <= r_cnt + 1'b1;
      if (o_last_sent)
        r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_reg_dumper.sv
// debug_reg_dumper: walks the register bank debug port and streams every
// word as bytes. Optional trailing XOR checksum byte: DUMP_CHECKSUM_EN.
module debug_reg_dumper #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_halt,
  output logic               o_ctrl_read_debug_reg,
  output logic [NB_REG-1:0]  o_addr_debug_unit,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);
  import debug_reg_dumper_pkg::*;

  state_t             r_state;
  logic [NB_REG-1:0]  r_idx;
  logic               r_done;
  logic               w_load;
  logic               w_last;
  logic [NB_BYTE-1:0] w_ser_data;
  logic               w_ser_valid;

  assign w_load = (r_state == S_LATCH);

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_word      (i_reg_data),
    .o_tx_data   (w_ser_data),
    .o_tx_valid  (w_ser_valid),
    .i_tx_ready  (i_tx_ready),
    .o_last_sent (w_last)
  );

`ifdef DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] r_csum;
  logic               r_csum_valid;

  assign o_tx_data  = r_csum_valid ? r_csum : w_ser_data;
  assign o_tx_valid = w_ser_valid | r_csum_valid;

  // XOR of every data byte accepted since the dump began
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      r_csum <= '0;
    else if (r_state == S_IDLE && i_start && i_halt)
      r_csum <= '0;
    else if (w_ser_valid && i_tx_ready)
      r_csum <= r_csum ^ w_ser_data;
  end
`else
  assign o_tx_data  = w_ser_data;
  assign o_tx_valid = w_ser_valid;
`endif

  assign o_busy                = (r_state != S_IDLE);
  assign o_ctrl_read_debug_reg = o_busy;
  assign o_addr_debug_unit     = r_idx;
  assign o_done                = r_done;

  // Dump sequencer: per register select, latch, send bytes, advance
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_csum_valid <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start && i_halt)
            r_state <= S_SELECT;
        end
        S_SELECT: r_state <= S_LATCH;
        S_LATCH:  r_state <= S_SEND;
        S_SEND: begin
          if (w_last)
            r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_idx == NB_REG'(N_REGS - 1)) begin
`ifdef DUMP_CHECKSUM_EN
            r_state      <= S_CSUM;
            r_csum_valid <= 1'b1;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
`endif
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_SELECT;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (i_tx_ready) begin
            r_csum_valid <= 1'b0;
            r_state      <= S_DONE;
            r_done       <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Scoreboard bench for debug_reg_dumper: expected bytes queued at stimulus,
// a negedge monitor pops and compares on every accepted byte.
module tb_debug_reg_dumper;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_halt;
  logic        o_ctrl;
  logic [4:0]  o_addr;
  logic [31:0] i_reg_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        rdy;
  logic        o_busy;
  logic        o_done;

  logic [31:0] mem [32];
  logic [7:0]  exp_q [$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  bit          rdy_mode = 1'b0;
  bit          hold_v = 1'b0;
  logic [7:0]  hold_d = '0;

  always #5 clk = ~clk;

  assign i_reg_data = mem[o_addr];

  debug_reg_dumper dut (
    .i_clock               (clk),
    .i_reset               (i_reset),
    .i_start               (i_start),
    .i_halt                (i_halt),
    .o_ctrl_read_debug_reg (o_ctrl),
    .o_addr_debug_unit     (o_addr),
    .i_reg_data            (i_reg_data),
    .o_tx_data             (o_tx_data),
    .o_tx_valid            (o_tx_valid),
    .i_tx_ready            (rdy),
    .o_busy                (o_busy),
    .o_done                (o_done)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_bytes(input int n, input bit with_cs);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = '0;
    for (int j = 0; j < n; j++) begin
      w = mem[j/4];
      exp_q.push_back(w[8*(3-(j%4)) +: 8]);
      cs = cs ^ w[8*(3-(j%4)) +: 8];
    end
`ifdef DUMP_CHECKSUM_EN
    if (with_cs) exp_q.push_back(cs);
`else
    if (with_cs) cs = '0;
`endif
  endtask

  task automatic start_dump();
    xfer_cnt = 0;
    @(negedge clk);
    i_start = 1'b1;
  endtask

  task automatic wait_done(input int bound, input int exp_cyc, input bit chk_cyc);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < bound) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      $display("FAIL done_timeout: got no o_done expected within %0d", bound);
    end else if (chk_cyc) begin
      chk("done_cycle", cyc, exp_cyc);
    end
  endtask

  // Ready driver and scoreboard monitor
  always begin
    @(negedge clk);
    if (rdy_mode) rdy = 1'($urandom_range(0, 1));
    else rdy = 1'b1;
    #1;
    if (i_reset) begin
      hold_v = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      if (hold_v) begin
        chk("stall_valid", o_tx_valid, 1);
        chk("stall_data", o_tx_data, hold_d);
      end
      if (o_tx_valid && xfer_cnt < 128) begin
        chk("addr", o_addr, xfer_cnt / 4);
        chk("ctrl", o_ctrl, 1);
      end
      if (o_tx_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_byte: got %0h expected none", o_tx_data);
        end else begin
          chk("byte", o_tx_data, exp_q.pop_front());
        end
        xfer_cnt++;
      end
      hold_v = o_tx_valid && !rdy;
      hold_d = o_tx_data;
    end
  end

  initial begin
    int  d0;
    int  c;
    bit  seen;
    int  exp_cyc;
`ifdef DUMP_CHECKSUM_EN
    exp_cyc = 226;
`else
    exp_cyc = 225;
`endif
    for (int k = 0; k < 32; k++) mem[k] = 32'hA0B0C000 + k;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_halt  = 1'b1;
    rdy     = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ctrl", o_ctrl, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_tx_data, 0);
    @(negedge clk);
    i_reset = 1'b0;

    // Test 1: full dump, ready high
    push_bytes(128, 1'b1);
    d0 = done_cnt;
    start_dump();
    wait_done(1000, exp_cyc, 1'b1);
    repeat (5) @(negedge clk);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_idle", o_busy, 0);

    // Test 2: start without halt is dropped
    i_halt = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (o_busy || o_tx_valid) seen = 1'b1;
    end
    i_halt = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (o_busy) seen = 1'b1;
    end
    chk("t2_gated", seen, 0);

    // Test 3: random ready
    rdy_mode = 1'b1;
    push_bytes(128, 1'b1);
    d0 = done_cnt;
    start_dump();
    wait_done(3000, 0, 1'b0);
    rdy_mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_q_empty", exp_q.size(), 0);
    chk("t3_done_cnt", done_cnt - d0, 1);

    // Test 4: reset while byte 2 of reg 7 is presented
    push_bytes(30, 1'b0);
    start_dump();
    @(negedge clk);
    i_start = 1'b0;
    c = 0;
    while (xfer_cnt < 30 && c < 500) begin
      @(negedge clk);
      #2;
      c++;
    end
    chk("t4_reach", xfer_cnt, 30);
    @(negedge clk);
    chk("t4_pre_addr", o_addr, 7);
    chk("t4_pre_data", o_tx_data, 8'hC0);
    i_reset = 1'b1;
    #2;
    chk("t4_valid", o_tx_valid, 0);
    chk("t4_busy", o_busy, 0);
    chk("t4_ctrl", o_ctrl, 0);
    chk("t4_addr", o_addr, 0);
    chk("t4_data", o_tx_data, 0);
    @(negedge clk);
    i_reset = 1'b0;
    chk("t4_q_empty", exp_q.size(), 0);
    push_bytes(128, 1'b1);
    d0 = done_cnt;
    start_dump();
    wait_done(1000, exp_cyc, 1'b1);
    repeat (5) @(negedge clk);
    chk("t4b_q_empty", exp_q.size(), 0);
    chk("t4b_done_cnt", done_cnt - d0, 1);

    // Test 5: restart and halt drop mid-dump are ignored
    push_bytes(128, 1'b1);
    d0 = done_cnt;
    start_dump();
    @(negedge clk);
    i_start = 1'b0;
    repeat (40) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_halt  = 1'b0;
    wait_done(1000, 0, 1'b0);
    repeat (30) @(negedge clk);
    chk("t5_q_empty", exp_q.size(), 0);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_idle", o_busy, 0);
    i_halt = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
